// File: rtl/multiplier_repadd_seq.sv
// Sequential multiplier that forms the product by repeated addition of one operand magnitude.
// Sign is resolved once at start and applied when the final sum is captured.
module multiplier_repadd_seq #(
  parameter int WIDTH    = 4,
  parameter int SIGNED   = 0,
  parameter int MIN_SWAP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     product_q, product_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  addend_q, addend_d;
  logic              neg_q, neg_d;

  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH-1:0]  count_init, addend_init;
  logic [PW-1:0]     acc_sum;

  // Magnitudes stay in WIDTH unsigned bits, so the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    a_neg = (SIGNED != 0) && multiplicand[WIDTH-1];
    b_neg = (SIGNED != 0) && multiplier[WIDTH-1];
    a_mag = a_neg ? (~multiplicand + WIDTH'(1)) : multiplicand;
    b_mag = b_neg ? (~multiplier + WIDTH'(1)) : multiplier;
    if (MIN_SWAP != 0) begin
      if (a_mag < b_mag) begin
        count_init  = a_mag;
        addend_init = b_mag;
      end else begin
        count_init  = b_mag;
        addend_init = a_mag;
      end
    end else begin
      count_init  = b_mag;
      addend_init = a_mag;
    end
  end

  assign acc_sum = acc_q + {{WIDTH{1'b0}}, addend_q};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    addend_d  = addend_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          count_d  = count_init;
          addend_d = addend_init;
          neg_d    = a_neg ^ b_neg;
          if (count_init == '0) begin
            state_d   = DONE;
            product_d = '0;
          end else begin
            state_d = ADD;
          end
        end
      end
      ADD: begin
        acc_d   = acc_sum;
        count_d = count_q - WIDTH'(1);
        // The last addition feeds the product directly so it is valid during DONE.
        if (count_q == WIDTH'(1)) begin
          state_d   = DONE;
          product_d = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      addend_q  <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      addend_q  <= addend_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == ADD) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_multiplier_repadd_seq.sv
// Bench for multiplier_repadd_seq: three configurations share stimulus and are checked
// every cycle against a cycle-count/arithmetic model, plus literal directed expectations.
module tb_multiplier_repadd_seq;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a     = 4'd0;
  logic [3:0] b     = 4'd0;

  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [7:0] prod_v [3];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Instance 0: unsigned, min-swap; 1: unsigned, iterate on multiplier; 2: signed, min-swap
  multiplier_repadd_seq #(.WIDTH(4), .SIGNED(0), .MIN_SWAP(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .multiplicand(a), .multiplier(b),
    .busy(busy_v[0]), .done(done_v[0]), .product(prod_v[0]));

  multiplier_repadd_seq #(.WIDTH(4), .SIGNED(0), .MIN_SWAP(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .multiplicand(a), .multiplier(b),
    .busy(busy_v[1]), .done(done_v[1]), .product(prod_v[1]));

  multiplier_repadd_seq #(.WIDTH(4), .SIGNED(1), .MIN_SWAP(1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .multiplicand(a), .multiplier(b),
    .busy(busy_v[2]), .done(done_v[2]), .product(prod_v[2]));

  task automatic checkOutput(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference: true multiplication of the operand values and the iteration count from magnitudes
  function automatic void modelOp(input int k, input logic [3:0] ai, input logic [3:0] bi,
                                  output int n, output logic [7:0] p);
    int av, bv, am, bm;
    av = int'(ai);
    bv = int'(bi);
    if (k == 2) begin
      if (av >= 8) av = av - 16;
      if (bv >= 8) bv = bv - 16;
    end
    am = (av < 0) ? -av : av;
    bm = (bv < 0) ? -bv : bv;
    if (k == 1) n = bm;
    else        n = (am < bm) ? am : bm;
    p = 8'(av * bv);
  endfunction

  int         cyc = 0;
  int         t_start [3];
  int         t_done  [3];
  bit         act     [3];
  logic [7:0] cur_p   [3];
  logic [7:0] pend_p  [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit ebusy;
      bit edone;
      if (rst) begin
        act[k]   = 1'b0;
        cur_p[k] = 8'd0;
        ebusy    = 1'b0;
        edone    = 1'b0;
      end else begin
        if (act[k] && cyc == t_done[k]) cur_p[k] = pend_p[k];
        ebusy = act[k] && (cyc > t_start[k]) && (cyc <= t_done[k]);
        edone = act[k] && (cyc == t_done[k]);
      end
      checkOutput($sformatf("dut%0d busy cyc%0d", k, cyc), int'(busy_v[k]), int'(ebusy));
      checkOutput($sformatf("dut%0d done cyc%0d", k, cyc), int'(done_v[k]), int'(edone));
      checkOutput($sformatf("dut%0d product cyc%0d", k, cyc), int'(prod_v[k]), int'(cur_p[k]));
      if (!rst && !ebusy && start) begin
        int n;
        modelOp(k, a, b, n, pend_p[k]);
        t_start[k] = cyc;
        t_done[k]  = cyc + 1 + n;
        act[k]     = 1'b1;
      end
    end
    cyc++;
  end

  int         lat [3];
  logic [7:0] prd [3];

  task automatic waitIdle();
    bit idle;
    idle  = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (busy_v == 3'b000) idle = 1'b1;
    end
    if (!idle) checkOutput("idle timeout", int'(busy_v), 0);
  endtask

  // One accepted operation; latency is counted in cycles after the accepting cycle
  task automatic applyStimulus(input logic [3:0] ai, input logic [3:0] bi, input bit glitch);
    waitIdle();
    @(posedge clk); #1;
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    for (int k = 0; k < 3; k++) begin
      lat[k] = -1;
      prd[k] = 8'd0;
    end
    for (int i = 1; i <= 40; i++) begin
      if (glitch && i == 2) begin
        start = 1'b1;
        a = ~ai;
        b = bi ^ 4'h5;
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (done_v[k] && lat[k] < 0) begin
          lat[k] = i;
          prd[k] = prod_v[k];
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(4'd4, 4'd3, 1'b0);
    checkOutput("u 4x3 latency", lat[0], 4);
    checkOutput("u 4x3 product", int'(prd[0]), 12);

    applyStimulus(4'd0, 4'd9, 1'b0);
    checkOutput("u 0x9 latency", lat[0], 1);
    checkOutput("u 0x9 product", int'(prd[0]), 0);

    applyStimulus(4'd15, 4'd15, 1'b1);
    checkOutput("u 15x15 latency", lat[0], 16);
    checkOutput("u 15x15 product", int'(prd[0]), 225);
    checkOutput("nomin 15x15 product", int'(prd[1]), 225);

    applyStimulus(4'd2, 4'd7, 1'b0);
    checkOutput("nomin 2x7 latency", lat[1], 8);
    checkOutput("nomin 2x7 product", int'(prd[1]), 14);
    checkOutput("min 2x7 latency", lat[0], 3);
    checkOutput("min 2x7 product", int'(prd[0]), 14);

    waitIdle();
    @(posedge clk); #1;
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("async reset busy", int'(busy_v), 0);
    checkOutput("async reset done", int'(done_v), 0);
    checkOutput("async reset product", int'(prod_v[0]), 0);
    checkOutput("async reset product nomin", int'(prod_v[1]), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(4'd4, 4'd3, 1'b0);
    checkOutput("post-reset latency", lat[0], 4);
    checkOutput("post-reset product", int'(prd[0]), 12);

    applyStimulus(4'h8, 4'd3, 1'b0);
    checkOutput("s -8x3 latency", lat[2], 4);
    checkOutput("s -8x3 product", int'(prd[2]), 8'hE8);

    applyStimulus(4'hD, 4'hB, 1'b0);
    checkOutput("s -3x-5 product", int'(prd[2]), 15);

    applyStimulus(4'h9, 4'h0, 1'b0);
    checkOutput("s -7x0 latency", lat[2], 1);
    checkOutput("s -7x0 product", int'(prd[2]), 0);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) == 0);
      a     = 4'($urandom);
      b     = 4'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    waitIdle();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
